data_mem_arbiter: RTL

- Shares the single-ported data memory between two requesters: requester 0 (core load/store unit) and requester 1 (DMA/debug port).
- Sits between the requesters and the data memory, and drives every data memory control input.
- Arbitrates between the two requesters, sequences the 2-cycle read (request cycle, then data cycle), and holds size/extension controls stable through the data cycle.
- Rejects out-of-range addresses with an error response instead of letting them alias in memory.

---
 rtl/yarp_pkg.sv | 23 ++
 rtl/data_mem_arbiter_rr_arb2.sv | 32 +++
 rtl/data_mem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/yarp_pkg.sv
// rtl/yarp_pkg.sv - shared types for the data memory path
// Purpose: access-size encoding, arbiter FSM states and requester ids.
// Ports: none (package).
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b11
  } mem_access_size_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RD_RESP  = 2'b01,
    ERR_RESP = 2'b10
  } arb_state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DMA  = 1'b1
  } req_id_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rtl/data_mem_arbiter_rr_arb2.sv - 2-input round-robin / fixed-priority picker
// Purpose: choose one of two requesters; the pointer register lives in the caller.
// Ports:
//   req_i    in  2  request vector
//   rr_ptr_i in  1  requester favoured when both request (round-robin mode only)
//   gnt_o    out 2  one-hot grant, 0 when nobody requests
//   winner_o out 1  id of the granted requester (REQ_CORE when nobody requests)
module rr_arb2
  import yarp_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] req_i,
  input  req_id_t    rr_ptr_i,
  output logic [1:0] gnt_o,
  output req_id_t    winner_o
);

  always_comb begin
    winner_o = REQ_CORE;
    gnt_o    = 2'b00;
    if (req_i == 2'b11) begin
      winner_o = RR_EN ? rr_ptr_i : REQ_CORE;
    end else if (req_i[1]) begin
      winner_o = REQ_DMA;
    end
    if (|req_i) begin
      gnt_o = (winner_o == REQ_DMA) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-requester arbiter in front of the single-ported data memory
// Purpose: arbitrate core LSU (0) and DMA/debug (1), sequence 2-cycle reads, reject
//          out-of-range addresses with a one-cycle error response.
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   req_i/wr_i/addr_i/wr_data_i         per-requester request, direction, address, write data
//   byte_en_i/zero_extnd_i              per-requester access size and load extension
//   gnt_o/rd_valid_o/err_o              one-hot accept / read-data-valid / error response
//   rd_data_o                           shared read data (0 unless rd_valid_o)
//   data_*_o                            memory control; data_mem_rd_data_i registered read data
module data_mem_arbiter
  import yarp_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 12,
  parameter bit RR_EN         = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      req_i,
  input  logic [1:0]      wr_i,
  input  logic [1:0][31:0] addr_i,
  input  logic [1:0][31:0] wr_data_i,
  input  logic [1:0][1:0] byte_en_i,
  input  logic [1:0]      zero_extnd_i,
  output logic [1:0]      gnt_o,
  output logic [1:0]      rd_valid_o,
  output logic [31:0]     rd_data_o,
  output logic [1:0]      err_o,
  output logic            data_req_o,
  output logic            data_wr_o,
  output logic [31:0]     data_addr_o,
  output logic [31:0]     data_wr_data_o,
  output logic [1:0]      data_byte_en_o,
  output logic            data_zero_extnd_o,
  input  logic [31:0]     data_mem_rd_data_i
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  req_id_t    r_rr_ptr;
  logic       r_owner;
  logic [1:0] r_byte_en;
  logic       r_zero_extnd;

  logic [1:0] w_arb_gnt;
  req_id_t    w_winner;
  logic       w_win_idx;
  logic       w_in_range;
  logic       w_grant_en;

  rr_arb2 #(.RR_EN(RR_EN)) u_rr_arb2 (
    .req_i    (req_i),
    .rr_ptr_i (r_rr_ptr),
    .gnt_o    (w_arb_gnt),
    .winner_o (w_winner)
  );

  assign w_win_idx  = (w_winner == REQ_DMA);
  assign w_in_range = (addr_i[w_win_idx][31:MEM_ADDR_BITS] == '0);
  // reset_n gates the grant so every output is 0 while reset is held.
  assign w_grant_en = reset_n && (r_state == IDLE) && (|req_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= REQ_CORE;
      r_owner      <= 1'b0;
      r_byte_en    <= 2'b00;
      r_zero_extnd <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_en) begin
        r_rr_ptr     <= (w_winner == REQ_CORE) ? REQ_DMA : REQ_CORE;
        r_owner      <= w_win_idx;
        r_byte_en    <= byte_en_i[w_win_idx];
        r_zero_extnd <= zero_extnd_i[w_win_idx];
      end
    end
  end

  always_comb begin
    w_next_state      = r_state;
    gnt_o             = 2'b00;
    rd_valid_o        = 2'b00;
    rd_data_o         = 32'h0;
    err_o             = 2'b00;
    data_req_o        = 1'b0;
    data_wr_o         = 1'b0;
    data_addr_o       = 32'h0;
    data_wr_data_o    = 32'h0;
    data_byte_en_o    = 2'b00;
    data_zero_extnd_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_en) begin
          gnt_o = w_arb_gnt;
          if (w_in_range) begin
            data_req_o        = 1'b1;
            data_wr_o         = wr_i[w_win_idx];
            data_addr_o       = addr_i[w_win_idx];
            data_wr_data_o    = wr_data_i[w_win_idx];
            data_byte_en_o    = byte_en_i[w_win_idx];
            data_zero_extnd_o = zero_extnd_i[w_win_idx];
            if (!wr_i[w_win_idx]) begin
              w_next_state = RD_RESP;
            end
          end else begin
            // Out-of-range: memory is not touched, answer with an error next cycle.
            w_next_state = ERR_RESP;
          end
        end
      end
      RD_RESP: begin
        // Memory extends its registered word combinationally, so size/extension
        // must still be presented during the data cycle.
        data_byte_en_o      = r_byte_en;
        data_zero_extnd_o   = r_zero_extnd;
        rd_data_o           = data_mem_rd_data_i;
        rd_valid_o[r_owner] = 1'b1;
        w_next_state        = IDLE;
      end
      ERR_RESP: begin
        err_o[r_owner] = 1'b1;
        w_next_state   = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule
